// File: rtl/uart_tx_serializer_if.sv
// Transmit-side bundle between the PIO exports and the UART serializer.
// master = software/PIO side, slave = serializer.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic [31:0]          bit_period;
    logic                 tx;
    logic [2:0]           tx_status;
    logic                 tx_done;

    modport master (
        output tx_data, tx_start, bit_period,
        input  tx, tx_status, tx_done
    );

    modport slave (
        input  tx_data, tx_start, bit_period,
        output tx, tx_status, tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter with a one-entry holding register. A rising edge on
// tx_start queues tx_data; frames are start, DATA_BITS LSB first, optional
// parity and STOP_BITS stop bits, each lasting the period latched at frame start.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int MIN_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_serializer_if.slave  bus
);
    localparam int              IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic            LAST_STOP = (STOP_BITS == 2);
    localparam logic [31:0]     MIN_P     = 32'(MIN_PERIOD);
    localparam logic            ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 hold_full_q, hold_full_d;
    logic                 overrun_q, overrun_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [31:0]          period_q, period_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 start_prev_q;

    logic                 start_edge;
    logic                 bit_end;
    logic                 transfer;
    logic                 done;
    logic [31:0]          eff_period;

    assign start_edge = bus.tx_start & ~start_prev_q;
    assign bit_end    = (cnt_q == 32'd0);
    assign eff_period = (bus.bit_period < MIN_P) ? MIN_P : bus.bit_period;

    // Next-state, bit timing, holding-register load and serial line value.
    always_comb begin
        // NOTE: every signal gets its default before the case so no path leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        parity_d    = parity_q;
        tx_d        = tx_q;
        transfer    = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) transfer = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    cnt_d     = period_q - 32'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = period_q - 32'd1;
                    if (bit_idx_q == LAST_IDX) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_d       = 1'b1;
                            stop_idx_d = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                    cnt_d      = period_q - 32'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == LAST_STOP) begin
                        done = 1'b1;
                        if (hold_full_q) begin
                            transfer = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                        cnt_d      = period_q - 32'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Held byte moves to the shifter; period and parity are frozen for the frame.
        if (transfer) begin
            state_d     = S_START;
            shift_d     = hold_q;
            parity_d    = (^hold_q) ^ ODD;
            period_d    = eff_period;
            cnt_d       = eff_period - 32'd1;
            tx_d        = 1'b0;
            hold_full_d = 1'b0;
        end

        // A load is accepted if the holding register is empty or is being emptied this edge.
        if (start_edge) begin
            if (!hold_full_q || transfer) begin
                hold_d      = bus.tx_data;
                hold_full_d = 1'b1;
                overrun_d   = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset forces an idle-high line at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            shift_q      <= '0;
            hold_full_q  <= 1'b0;
            overrun_q    <= 1'b0;
            cnt_q        <= '0;
            period_q     <= MIN_P;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            start_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            hold_full_q  <= hold_full_d;
            overrun_q    <= overrun_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            start_prev_q <= bus.tx_start;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.tx_done   = done;
    assign bus.tx_status = {overrun_q, hold_full_q, (state_q != S_IDLE)};
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame shape, latency, parity,
// holding register / overrun, level-held start, period clamp and reset abort.
module tb_uart_tx_serializer;
    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_serializer_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) bus_e ();
    uart_tx_serializer_if #(.DATA_BITS(8)) bus_o ();

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MIN_PERIOD(2))
        u_dut (.clk(clk), .reset(reset), .bus(bus0));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .MIN_PERIOD(2))
        u_dut_even (.clk(clk), .reset(reset), .bus(bus_e));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .MIN_PERIOD(2))
        u_dut_odd (.clk(clk), .reset(reset), .bus(bus_o));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        else
            n_pass++;
    endtask

    function automatic logic tx_of(input int sel);
        case (sel)
            1:       return bus_e.tx;
            2:       return bus_o.tx;
            default: return bus0.tx;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            1:       return bus_e.tx_done;
            2:       return bus_o.tx_done;
            default: return bus0.tx_done;
        endcase
    endfunction

    // Expected line level for frame bit idx (0 = start bit).
    function automatic logic frame_bit(input logic [7:0] d, input int idx, input int par_mode);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && par_mode != 0) return (^d) ^ (par_mode == 2);
        return 1'b1;
    endfunction

    // Called on the negedge showing frame cycle 1; returns on the negedge of the last cycle.
    task automatic check_frame(input int sel, input logic [7:0] d, input int period,
                               input int par_mode, input string tag);
        int nbits = (par_mode != 0) ? 11 : 10;
        int total = nbits * period;
        for (int c = 0; c < total; c++) begin
            check($sformatf("%s tx bit%0d cyc%0d", tag, c / period, c), 32'(tx_of(sel)),
                  32'(frame_bit(d, c / period, par_mode)));
            check($sformatf("%s done cyc%0d", tag, c), 32'(done_of(sel)), 32'(c == total - 1));
            if (c < total - 1) @(negedge clk);
        end
    endtask

    task automatic pulse_start(input logic [7:0] d, input logic [31:0] p);
        bus0.tx_data    = d;
        bus0.bit_period = p;
        bus0.tx_start   = 1'b1;
        @(negedge clk);
        bus0.tx_start   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic low_seen;
        reset = 1'b1;
        bus0.tx_data = 8'h00; bus0.tx_start = 1'b0; bus0.bit_period = 32'd4;
        bus_e.tx_data = 8'h00; bus_e.tx_start = 1'b0; bus_e.bit_period = 32'd4;
        bus_o.tx_data = 8'h00; bus_o.tx_start = 1'b0; bus_o.bit_period = 32'd4;

        // Reset state
        @(negedge clk);
        check("reset tx", 32'(bus0.tx), 32'd1);
        check("reset status", 32'(bus0.tx_status), 32'd0);
        check("reset done", 32'(bus0.tx_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic 0x55 frame at 4 clocks/bit, 2-clock start latency
        pulse_start(8'h55, 32'd4);
        check("0x55 latency tx", 32'(bus0.tx), 32'd1);
        check("0x55 held status", 32'(bus0.tx_status), 32'b010);
        @(negedge clk);
        check_frame(0, 8'h55, 4, 0, "0x55");
        @(negedge clk);
        check("0x55 idle status", 32'(bus0.tx_status), 32'd0);
        check("0x55 idle tx", 32'(bus0.tx), 32'd1);

        // Holding register, overrun and back-to-back frames
        pulse_start(8'hA5, 32'd2);
        @(negedge clk);
        fork
            begin
                check_frame(0, 8'hA5, 2, 0, "0xA5");
                @(negedge clk);
                check_frame(0, 8'h3C, 2, 0, "0x3C b2b");
            end
            begin
                @(negedge clk);
                bus0.tx_data = 8'h3C; bus0.tx_start = 1'b1;
                @(negedge clk);
                bus0.tx_start = 1'b0;
                @(negedge clk);
                check("second load status", 32'(bus0.tx_status), 32'b011);
                bus0.tx_data = 8'h99; bus0.tx_start = 1'b1;
                @(negedge clk);
                bus0.tx_start = 1'b0;
                @(negedge clk);
                check("third load overrun", 32'(bus0.tx_status), 32'b111);
            end
        join
        @(negedge clk);
        check("dropped byte not sent", 32'(bus0.tx_status), 32'b100);
        pulse_start(8'h0F, 32'd2);
        check("accepted load clears overrun", 32'(bus0.tx_status), 32'b010);
        @(negedge clk);
        check_frame(0, 8'h0F, 2, 0, "0x0F");
        @(negedge clk);

        // tx_start held high for 50 clocks gives exactly one frame
        bus0.tx_data = 8'h81; bus0.bit_period = 32'd2; bus0.tx_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_frame(0, 8'h81, 2, 0, "held 0x81");
        low_seen = 1'b0;
        repeat (29) begin
            @(negedge clk);
            if (!bus0.tx) low_seen = 1'b1;
        end
        check("held level single frame", 32'(low_seen), 32'd0);
        check("held level idle", 32'(bus0.tx_status), 32'd0);
        bus0.tx_start = 1'b0;
        @(negedge clk);
        bus0.tx_data = 8'h42; bus0.tx_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_frame(0, 8'h42, 2, 0, "re-armed 0x42");
        bus0.tx_start = 1'b0;
        @(negedge clk);

        // Period clamp, and a mid-frame period change applying to the next frame only
        pulse_start(8'hF0, 32'd0);
        @(negedge clk);
        fork
            begin
                check_frame(0, 8'hF0, 2, 0, "clamped 0xF0");
                @(negedge clk);
                check_frame(0, 8'h3A, 10, 0, "period10 0x3A");
            end
            begin
                @(negedge clk);
                @(negedge clk);
                bus0.bit_period = 32'd10; bus0.tx_data = 8'h3A; bus0.tx_start = 1'b1;
                @(negedge clk);
                bus0.tx_start = 1'b0;
            end
        join
        @(negedge clk);
        check("after period test idle", 32'(bus0.tx_status), 32'd0);

        // Even and odd parity on 0x07 (three ones)
        bus_e.tx_data = 8'h07; bus_e.bit_period = 32'd3; bus_e.tx_start = 1'b1;
        bus_o.tx_data = 8'h07; bus_o.bit_period = 32'd3; bus_o.tx_start = 1'b1;
        @(negedge clk);
        bus_e.tx_start = 1'b0;
        bus_o.tx_start = 1'b0;
        @(negedge clk);
        fork
            check_frame(1, 8'h07, 3, 1, "even 0x07");
            check_frame(2, 8'h07, 3, 2, "odd 0x07");
        join
        @(negedge clk);
        check("even idle", 32'(bus_e.tx_status), 32'd0);

        // Reset during data bit 3 aborts immediately; next frame is clean
        pulse_start(8'hC3, 32'd4);
        @(negedge clk);
        repeat (17) @(negedge clk);
        check("pre-reset data bit3", 32'(bus0.tx), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mid-frame reset tx", 32'(bus0.tx), 32'd1);
        check("mid-frame reset status", 32'(bus0.tx_status), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset idle tx", 32'(bus0.tx), 32'd1);
        pulse_start(8'h5A, 32'd4);
        @(negedge clk);
        check_frame(0, 8'h5A, 4, 0, "post-reset 0x5A");
        @(negedge clk);
        check("post-reset final idle", 32'(bus0.tx_status), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
